ripple_count_monitor: RTL
=========================

// Module: ripple_count_monitor
// PURPOSE
//  Downstream consumer of the 4-bit T_FF ripple counter: samples its asynchronous,
//  glitchy q[] into the clk domain and filters it to a stable value. Extends the
//  range by counting wraps and flags a programmable compare match. Delivers
//  snapshots of the extended count over a valid/ready handshake.
// PARAMETERS
//  CNT_W          4   width of ripple counter input
//  EXT_W          4   width of wrap (epoch) counter; ext_count = {wrap_cnt, stable}
//  SYNC_STAGES    2   synchronizer flops per input bit (>=2)
//  STABLE_CYCLES  2   consecutive identical samples required to accept a value (>=1)
// PORTS
//  clk          in   1            system clock
//  reset        in   1            asynchronous, active-high reset
//  cnt_in       in   CNT_W        ripple counter q[], asynchronous to clk
//  sw_clr       in   1            sync clear of wrap_cnt/stable/filter/ovf (pulse with counter reset)
//  cmp_value    in   CNT_W+EXT_W  match threshold for ext_count
//  ext_count    out  CNT_W+EXT_W  {wrap_cnt, stable} filtered extended count
//  wrap_pulse   out  1            1-cycle pulse when a wrap is detected
//  match_pulse  out  1            1-cycle pulse when ext_count becomes == cmp_value
//  snap_req     in   1            request a snapshot of ext_count
//  snap_valid   out  1            snapshot held on snap_data
//  snap_ready   in   1            consumer accepts snapshot
//  snap_data    out  CNT_W+EXT_W  captured ext_count
//  snap_miss    out  1            sticky: a snap_req was dropped while busy
//  ovf          out  1            sticky wrap-counter saturation flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all flops, all outputs 0; FSM in IDLE. sw_clr (sync) has the same effect
//   except the synchronizer chain and FSM/snap_* keep running; sw_clr has priority.
//  Sync: cnt_in passes SYNC_STAGES flops -> sync_q. Bits are independent (ripple).
//  Filter: cand reg + run ctr (0..STABLE_CYCLES). sync_q!=cand: cand<=sync_q, run<=1;
//   else run<=min(run+1,STABLE_CYCLES). When next run==STABLE_CYCLES and cand!=stable:
//   stable<=cand (an "update"). Input-to-ext_count latency = SYNC_STAGES+STABLE_CYCLES
//   cycles for a quiet input (4 with defaults). STABLE_CYCLES=1 accepts next cycle.
//  Wrap: on update with new stable < old stable: wrap_cnt<=wrap_cnt+1, wrap_pulse=1
//   next cycle. Multiple counts skipped between updates are not reconstructed.
//  Match: match_pulse=1 for exactly 1 cycle after an update (stable or wrap_cnt)
//   makes ext_count==cmp_value; holding equal does not re-fire; cmp_value change alone
//   does not fire.
//  Snapshot FSM: IDLE --snap_req--> HOLD: snap_data<=ext_count, snap_valid<=1.
//   HOLD: snap_data/snap_valid stable until snap_ready.
//   HOLD & snap_ready & !snap_req -> IDLE, snap_valid<=0.
//   HOLD & snap_ready & snap_req -> recapture, stay HOLD (back-to-back, no bubble).
//   HOLD & !snap_ready & snap_req -> request dropped, snap_miss<=1 (sticky until reset).
//   snap_ready in IDLE ignored.
//  Counter reset mid-run: without sw_clr, drop to 0 is seen as a wrap (by design).
// CONFIGURATION
//  MON_SAT_EN defined: wrap_cnt saturates at all-ones; a wrap at all-ones keeps
//   wrap_cnt, sets ovf=1 (sticky, cleared by reset/sw_clr), and wrap_pulse still fires.
//  MON_SAT_EN undefined: wrap_cnt wraps modulo 2^EXT_W; ovf tied 0.
// TESTING
//  T1 reset mid-count -> all outputs 0 within same edge; after release, cnt_in=5 quiet
//   -> ext_count=0x05 exactly 4 cycles later.
//  T2 cnt_in glitch 7->0->8 with 0 held 1 cycle -> ext_count goes 0x07->0x08, no wrap_pulse.
//  T3 step cnt_in 0..15 then 0 (each held 6 cycles) -> ext_count 0x0F->0x10, one
//   wrap_pulse; cmp_value=0x10 -> one match_pulse, same cycle as wrap_pulse.
//  T4 snap_req with ext_count=0x23, snap_ready low 5 cycles -> snap_valid=1,
//   snap_data=0x23 stable; 2nd req in hold -> snap_miss=1; ready+req -> new capture.
//  T5 MON_SAT_EN, 17 wraps -> wrap_cnt=0xF, ovf=1; without macro -> wrap_cnt=0x1, ovf=0.
//  T6 sw_clr with ext_count=0x5A -> ext_count=0x00 next cycle, no wrap/match pulses.

Source files
------------

// File: rtl/ripple_count_monitor_if.sv
// Snapshot handshake bundle for ripple_count_monitor.
// master: the monitor (drives valid/data/miss); slave: the snapshot consumer.
interface ripple_count_monitor_if #(
  parameter int unsigned DataW = 8
);
  logic             snap_req;
  logic             snap_valid;
  logic             snap_ready;
  logic [DataW-1:0] snap_data;
  logic             snap_miss;

  modport master (
    input  snap_req,
    input  snap_ready,
    output snap_valid,
    output snap_data,
    output snap_miss
  );

  modport slave (
    output snap_req,
    output snap_ready,
    input  snap_valid,
    input  snap_data,
    input  snap_miss
  );
endinterface

// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor: samples an asynchronous ripple counter into the clk domain,
// filters glitches, extends the range with a wrap (epoch) counter, flags compare
// matches and hands out snapshots of the extended count over a valid/ready handshake.
// Optional feature: define MON_SAT_EN to make the wrap counter saturate and drive a
// sticky overflow flag; otherwise the wrap counter rolls over and ovf_o is tied low.
module ripple_count_monitor #(
  parameter int unsigned CntW         = 4,
  parameter int unsigned ExtW         = 4,
  parameter int unsigned SyncStages   = 2,
  parameter int unsigned StableCycles = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CntW-1:0]      cnt_in_i,
  input  logic                 sw_clr_i,
  input  logic [CntW+ExtW-1:0] cmp_value_i,
  output logic [CntW+ExtW-1:0] ext_count_o,
  output logic                 wrap_pulse_o,
  output logic                 match_pulse_o,
  output logic                 ovf_o,
  ripple_count_monitor_if.master snap_if
);

  localparam int unsigned TotW = CntW + ExtW;
  localparam int unsigned RunW = $clog2(StableCycles + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(StableCycles);

  // ---------------------------------------------------------------------------
  // Synchronizer: bits are independent, so a plain per-bit flop chain is enough.
  // ---------------------------------------------------------------------------
  logic [SyncStages-1:0][CntW-1:0] sync_q;
  logic [CntW-1:0]                 sync_val;

  // Per-bit synchronizer chain; not affected by sw_clr
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], cnt_in_i};
    end
  end

  assign sync_val = sync_q[SyncStages-1];

  // ---------------------------------------------------------------------------
  // Glitch filter: a value is accepted after StableCycles identical samples.
  // ---------------------------------------------------------------------------
  logic [CntW-1:0] cand_q, cand_d;
  logic [RunW-1:0] run_q, run_d;
  logic [CntW-1:0] stable_q, stable_d;
  logic            update;

  // Candidate/run-length tracking and update decision
  always_comb begin
    cand_d = cand_q;
    run_d  = run_q;
    if (sync_val != cand_q) begin
      cand_d = sync_val;
      run_d  = RunW'(1);
    end else if (run_q != RunMax) begin
      run_d = run_q + 1'b1;
    end
    // Judge against the next candidate so StableCycles=1 accepts on the first sample
    update = (run_d == RunMax) && (cand_d != stable_q);
    if (sw_clr_i) begin
      cand_d = '0;
      run_d  = '0;
      update = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Wrap counter and compare match.
  // ---------------------------------------------------------------------------
  logic [ExtW-1:0] wrap_cnt_q, wrap_cnt_d;
  logic            wrap_det;
  logic            wrap_pulse_q, wrap_pulse_d;
  logic            match_q, match_d;
`ifdef MON_SAT_EN
  logic            ovf_q, ovf_d;
`endif

  // A drop in the accepted value means the ripple counter rolled over
  always_comb begin
    wrap_det   = update && (cand_d < stable_q);
    wrap_cnt_d = wrap_cnt_q;
    stable_d   = stable_q;
`ifdef MON_SAT_EN
    ovf_d      = ovf_q;
`endif
    if (wrap_det) begin
`ifdef MON_SAT_EN
      if (&wrap_cnt_q) begin
        ovf_d = 1'b1;
      end else begin
        wrap_cnt_d = wrap_cnt_q + 1'b1;
      end
`else
      wrap_cnt_d = wrap_cnt_q + 1'b1;
`endif
    end
    if (update) begin
      stable_d = cand_d;
    end
    // Only an update can fire a match; a moving threshold alone never does
    match_d      = update && ({wrap_cnt_d, stable_d} == cmp_value_i);
    wrap_pulse_d = wrap_det;
    if (sw_clr_i) begin
      wrap_cnt_d   = '0;
      stable_d     = '0;
      match_d      = 1'b0;
      wrap_pulse_d = 1'b0;
`ifdef MON_SAT_EN
      ovf_d        = 1'b0;
`endif
    end
  end

  // Filter, extended count and pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q       <= '0;
      run_q        <= '0;
      stable_q     <= '0;
      wrap_cnt_q   <= '0;
      wrap_pulse_q <= 1'b0;
      match_q      <= 1'b0;
    end else begin
      cand_q       <= cand_d;
      run_q        <= run_d;
      stable_q     <= stable_d;
      wrap_cnt_q   <= wrap_cnt_d;
      wrap_pulse_q <= wrap_pulse_d;
      match_q      <= match_d;
    end
  end

`ifdef MON_SAT_EN
  // Sticky saturation flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  assign ext_count_o   = {wrap_cnt_q, stable_q};
  assign wrap_pulse_o  = wrap_pulse_q;
  assign match_pulse_o = match_q;

  // ---------------------------------------------------------------------------
  // Snapshot FSM.
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {StIdle, StHold} snap_state_e;

  snap_state_e     state_q, state_d;
  logic            snap_valid;
  logic            capture;
  logic            miss_set;
  logic [TotW-1:0] snap_data_q;
  logic            snap_miss_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a request accepted together with ready keeps us in HOLD
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (snap_if.snap_req) state_d = StHold;
      StHold:  if (snap_if.snap_ready && !snap_if.snap_req) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode: capture enable, dropped-request detect and valid
  always_comb begin
    capture  = 1'b0;
    miss_set = 1'b0;
    unique case (state_q)
      StIdle: capture = snap_if.snap_req;
      StHold: begin
        capture  = snap_if.snap_ready && snap_if.snap_req;
        miss_set = !snap_if.snap_ready && snap_if.snap_req;
      end
      default: ;
    endcase
    snap_valid = (state_q == StHold);
  end

  // Snapshot data and sticky miss flag; sw_clr deliberately leaves these alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_data_q <= '0;
      snap_miss_q <= 1'b0;
    end else begin
      if (capture) begin
        snap_data_q <= ext_count_o;
      end
      if (miss_set) begin
        snap_miss_q <= 1'b1;
      end
    end
  end

  assign snap_if.snap_valid = snap_valid;
  assign snap_if.snap_data  = snap_data_q;
  assign snap_if.snap_miss  = snap_miss_q;

endmodule
